lfsr_gen: RTL and testbench

Parametrised successor to the fixed 5-bit LFSR. It provides a W-bit LFSR with a build-time tap mask and a runtime choice of Fibonacci or Galois form. It also offers multi-step advance per clock, seed load, enable gating, period-wrap detection and all-zero lockup flagging. It is used as a PRBS/scrambler/test-pattern source wherever a fixed 5-bit LFSR was used before.

---
 rtl/lfsr_gen.sv | 118 +++++++++++
 tb/tb_lfsr_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: W-bit LFSR, runtime Fibonacci/Galois form, STEPS shifts per enabled clock,
// seed load, period-wrap pulse and lockup flag. Macro LFSR_LOCKUP_RECOVER_EN enables auto-reseed from 0.

// One single-shift of the register in either form.
module lfsr_step #(
    parameter int             W    = 5,
    parameter logic [W-1:0]   TAPS = 'b10100
) (
    input  logic [W-1:0] r,
    input  logic         mode,
    output logic [W-1:0] nxt
);
    always_comb begin
        nxt = '0;
        if (mode) begin
            // Galois: TAPS[W-1] is implied by the feedback into bit 0
            nxt[0] = r[W-1];
            for (int i = 1; i < W; i++)
                nxt[i] = r[i-1] ^ (r[W-1] & TAPS[i-1]);
        end else begin
            nxt = {r[W-2:0], ^(r & TAPS)};
        end
    end
endmodule

module lfsr_gen #(
    parameter int          W     = 5,
    parameter logic [31:0] TAPS  = 32'b10100,
    parameter logic [31:0] SEED  = 32'b00001,
    parameter int          STEPS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         mode,
    input  logic         load,
    input  logic [W-1:0] seed_in,
    output logic [W-1:0] q,
    output logic         bit_out,
    output logic         wrap,
    output logic         lockup
);
    localparam logic [W-1:0] TAPS_W = TAPS[W-1:0];
    localparam logic [W-1:0] SEED_W = SEED[W-1:0];

    if (W < 3 || W > 32) begin : g_bad_w
        $error("lfsr_gen: W must be within 3..32");
    end
    if (TAPS_W[W-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS[W-1] must be set");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end
    if (STEPS < 1 || STEPS > W) begin : g_bad_steps
        $error("lfsr_gen: STEPS must be within 1..W");
    end

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] start;
        logic         wrap;
        logic         lockup;
    } st_t;

    st_t cur, nxt;

    // Combinational chain of STEPS single shifts; the whole advance lands in one clock.
    logic [STEPS:0][W-1:0] chain;
    assign chain[0] = cur.q;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        lfsr_step #(.W(W), .TAPS(TAPS_W)) u_step (
            .r    (chain[s]),
            .mode (mode),
            .nxt  (chain[s+1])
        );
    end

    always_comb begin
        nxt      = cur;
        nxt.wrap = 1'b0;
        if (load) begin
            nxt.q      = seed_in;
            nxt.start  = seed_in;
            nxt.lockup = (seed_in == '0);
        end
`ifdef LFSR_LOCKUP_RECOVER_EN
        else if (cur.lockup) begin
            nxt.q      = SEED_W;
            nxt.start  = SEED_W;
            nxt.lockup = 1'b0;
        end
`endif
        // A locked register stays put; en must not pulse wrap against a zero start.
        else if (en && !cur.lockup) begin
            nxt.q      = chain[STEPS];
            nxt.wrap   = (chain[STEPS] == cur.start);
            nxt.lockup = (chain[STEPS] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur.q      <= SEED_W;
            cur.start  <= SEED_W;
            cur.wrap   <= 1'b0;
            cur.lockup <= 1'b0;
        end else begin
            cur <= nxt;
        end
    end

    assign q       = cur.q;
    assign bit_out = cur.q[W-1];
    assign wrap    = cur.wrap;
    assign lockup  = cur.lockup;
endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: 5-bit STEPS=1 and STEPS=2 instances sharing stimulus.
module tb_lfsr_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b0, en = 1'b0, mode = 1'b0, load = 1'b0;
    logic [4:0] seed_in = '0;
    logic [4:0] q, q2;
    logic       bit_out, wrap, lockup, bit_out2, wrap2, lockup2;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];
    logic       exp_w[$];

    always #5 clk = ~clk;

    lfsr_gen #(.W(5), .TAPS(32'b10100), .SEED(32'b00001), .STEPS(1)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .seed_in(seed_in),
        .q(q), .bit_out(bit_out), .wrap(wrap), .lockup(lockup));

    lfsr_gen #(.W(5), .TAPS(32'b10100), .SEED(32'b00001), .STEPS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .seed_in(seed_in),
        .q(q2), .bit_out(bit_out2), .wrap(wrap2), .lockup(lockup2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        en = 1'b1; load = 1'b1; seed_in = 5'b11111;
        tick();
        do_reset();
        n_vec++;
        if (q !== 5'b00001 || wrap !== 1'b0 || lockup !== 1'b0 || bit_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset q=%b wrap=%b lockup=%b bit=%b, need 00001/0/0/0", q, wrap, lockup, bit_out);
        end
        n_vec++;
        if (q2 !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_steps2 q=%b need 00001", q2);
        end
    endtask

    task automatic test_seq(input logic m, input int n, input logic [4:0] vals[8], input string nm);
        logic [4:0] e;
        do_reset();
        mode = m; en = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(vals[i]);
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (q !== e || bit_out !== e[4]) begin
                n_err++;
                $display("FAIL %s step%0d q=%b bit=%b, need %b", nm, i + 1, q, bit_out, e);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_period(input logic m);
        bit seen[32];
        logic ew;
        int steps;
        foreach (seen[i]) seen[i] = 1'b0;
        do_reset();
        mode = m; en = 1'b1;
        seen[1] = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            exp_w.push_back(c == 31);
            tick();
            ew = exp_w.pop_front();
            n_vec++;
            if (wrap !== ew) begin
                n_err++;
                $display("FAIL period_m%0d_wrap cycle%0d wrap=%b need %b", m, c, wrap, ew);
            end
            if (c < 31) begin
                n_vec++;
                if (q === 5'b0 || seen[q]) begin
                    n_err++;
                    $display("FAIL period_m%0d_distinct cycle%0d q=%b repeated or zero", m, c, q);
                end
                seen[q] = 1'b1;
            end else begin
                n_vec++;
                if (q !== 5'b00001) begin
                    n_err++;
                    $display("FAIL period_m%0d_end q=%b need 00001", m, q);
                end
            end
        end
        // Gated enable: wrap must still land on the 31st enabled step.
        do_reset();
        steps = 0;
        for (int c = 0; c < 100 && steps < 31; c++) begin
            en = c[0];
            if (en) steps++;
            exp_w.push_back(en && steps == 31);
            tick();
            ew = exp_w.pop_front();
            n_vec++;
            if (wrap !== ew) begin
                n_err++;
                $display("FAIL toggle_m%0d_wrap cycle%0d wrap=%b need %b", m, c, wrap, ew);
            end
        end
        en = 1'b0;
        n_vec++;
        if (steps != 31 || q !== 5'b00001) begin
            n_err++;
            $display("FAIL toggle_m%0d_end steps=%0d q=%b need 31/00001", m, steps, q);
        end
    endtask

    task automatic test_steps2;
        logic [4:0] e;
        logic ew;
        do_reset();
        mode = 1'b0; en = 1'b1;
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b10010);
        for (int c = 1; c <= 31; c++) begin
            exp_w.push_back(c == 31);
            tick();
            ew = exp_w.pop_front();
            if (c <= 2) begin
                e = exp_q.pop_front();
                n_vec++;
                if (q2 !== e) begin
                    n_err++;
                    $display("FAIL steps2_q cycle%0d q=%b need %b", c, q2, e);
                end
            end
            n_vec++;
            if (wrap2 !== ew) begin
                n_err++;
                $display("FAIL steps2_wrap cycle%0d wrap=%b need %b", c, wrap2, ew);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_lockup;
        do_reset();
        load = 1'b1; seed_in = 5'b00000; en = 1'b1;
        tick();
        load = 1'b0;
        n_vec++;
        if (q !== 5'b0 || lockup !== 1'b1) begin
            n_err++;
            $display("FAIL lockup_load q=%b lockup=%b need 00000/1", q, lockup);
        end
`ifdef LFSR_LOCKUP_RECOVER_EN
        tick();
        n_vec++;
        if (q !== 5'b00001 || lockup !== 1'b0 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL lockup_recover q=%b lockup=%b wrap=%b need 00001/0/0", q, lockup, wrap);
        end
        tick();
        n_vec++;
        if (q !== 5'b00010) begin
            n_err++;
            $display("FAIL lockup_after q=%b need 00010", q);
        end
`else
        for (int c = 0; c < 5; c++) begin
            mode = c[0];
            tick();
            n_vec++;
            if (q !== 5'b0 || lockup !== 1'b1 || wrap !== 1'b0) begin
                n_err++;
                $display("FAIL lockup_hold cycle%0d q=%b lockup=%b wrap=%b need 00000/1/0", c, q, lockup, wrap);
            end
        end
        mode = 1'b0;
`endif
        load = 1'b1; seed_in = 5'b10110;
        tick();
        load = 1'b0; en = 1'b0;
        n_vec++;
        if (q !== 5'b10110 || lockup !== 1'b0) begin
            n_err++;
            $display("FAIL lockup_exit q=%b lockup=%b need 10110/0", q, lockup);
        end
    endtask

    task automatic test_load_en;
        logic ew;
        do_reset();
        mode = 1'b0; en = 1'b1;
        tick(); tick();
        load = 1'b1; seed_in = 5'b10110;
        tick();
        load = 1'b0;
        n_vec++;
        if (q !== 5'b10110 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL load_en q=%b wrap=%b need 10110/0", q, wrap);
        end
        tick();
        n_vec++;
        if (q !== 5'b01100) begin
            n_err++;
            $display("FAIL load_step q=%b need 01100", q);
        end
        for (int c = 2; c <= 31; c++) begin
            exp_w.push_back(c == 31);
            tick();
            ew = exp_w.pop_front();
            n_vec++;
            if (wrap !== ew) begin
                n_err++;
                $display("FAIL load_wrap cycle%0d wrap=%b need %b", c, wrap, ew);
            end
        end
        n_vec++;
        if (q !== 5'b10110) begin
            n_err++;
            $display("FAIL load_wrap_q q=%b need 10110", q);
        end
        tick(); tick();
        reset = 1'b1; load = 1'b1; seed_in = 5'b10110;
        tick();
        reset = 1'b0; load = 1'b0; en = 1'b0;
        n_vec++;
        if (q !== 5'b00001 || wrap !== 1'b0 || lockup !== 1'b0) begin
            n_err++;
            $display("FAIL reset_over_load q=%b wrap=%b lockup=%b need 00001/0/0", q, wrap, lockup);
        end
        en = 1'b0;
        tick();
        n_vec++;
        if (q !== 5'b00001 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL hold q=%b wrap=%b need 00001/0", q, wrap);
        end
    endtask

    initial begin
        logic [4:0] fib[8];
        logic [4:0] gal[8];
        fib = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101, 5'b0, 5'b0, 5'b0};
        gal = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01001, 5'b10010, 5'b01101, 5'b0};
        test_reset();
        test_seq(1'b0, 5, fib, "fib");
        test_seq(1'b1, 7, gal, "galois");
        test_period(1'b0);
        test_period(1'b1);
        test_steps2();
        test_lockup();
        test_load_en();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
